stump_alu: RTL and testbench



---
 rtl/stump_alu.sv | 96 +++++++++
 tb/tb_stump_alu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stump_alu.sv
// rtl/stump_alu.sv - registered 16-bit ALU (ADD/ADC/SUB/SBC/AND/OR) producing NZVC flags
// Optional: define STUMP_ALU_LDST_EN to enable LD/ST (func 6/7) address addition.
module stump_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] operand_A,
    input  logic [15:0] operand_B,
    input  logic [2:0]  func,
    input  logic        c_in,
    input  logic        csh,
    output logic [15:0] result,
    output logic [3:0]  flags_out
);

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_ADC = 3'd1;
    localparam logic [2:0] FN_SUB = 3'd2;
    localparam logic [2:0] FN_SBC = 3'd3;
    localparam logic [2:0] FN_AND = 3'd4;
    localparam logic [2:0] FN_OR  = 3'd5;

    logic [15:0] b_eff;
    logic        carry;
    logic        arith;
    logic        kill;
    logic [16:0] sum;
    logic [15:0] logic_res;
    logic [15:0] next_result;
    logic [3:0]  next_flags;
    logic        n_flag;
    logic        z_flag;
    logic        v_flag;
    logic        c_flag;

    always_comb begin
        b_eff     = operand_B;
        carry     = 1'b0;
        arith     = 1'b1;
        kill      = 1'b0;
        logic_res = 16'h0000;
        case (func)
            FN_ADD: carry = 1'b0;
            FN_ADC: carry = c_in;
            FN_SUB: begin
                b_eff = ~operand_B;
                carry = 1'b1;
            end
            FN_SBC: begin
                b_eff = ~operand_B;
                carry = c_in;
            end
            FN_AND: begin
                arith     = 1'b0;
                logic_res = operand_A & operand_B;
            end
            FN_OR: begin
                arith     = 1'b0;
                logic_res = operand_A | operand_B;
            end
            default: begin
`ifdef STUMP_ALU_LDST_EN
                carry = 1'b0;
`else
                kill  = 1'b1;
`endif
            end
        endcase
    end

    assign sum = {1'b0, operand_A} + {1'b0, b_eff} + {16'b0, carry};

    // Overflow: adder inputs agree in sign but the sum sign differs.
    always_comb begin
        next_result = arith ? sum[15:0] : logic_res;
        n_flag      = next_result[15];
        z_flag      = (next_result == 16'h0000);
        v_flag      = arith & (operand_A[15] == b_eff[15]) & (sum[15] != operand_A[15]);
        c_flag      = arith ? sum[16] : csh;
        next_flags  = {n_flag, z_flag, v_flag, c_flag};
        if (kill) begin
            next_result = 16'h0000;
            next_flags  = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 16'h0000;
            flags_out <= 4'b0000;
        end else begin
            result    <= next_result;
            flags_out <= next_flags;
        end
    end

endmodule

// File: tb/tb_stump_alu.sv
// tb/tb_stump_alu.sv - self-checking bench for stump_alu: directed table, reset sequence, random vs model
module tb_stump_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] operand_A;
    logic [15:0] operand_B;
    logic [2:0]  func;
    logic        c_in;
    logic        csh;
    logic [15:0] result;
    logic [3:0]  flags_out;

    int checks = 0;
    int errors = 0;

    stump_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .func      (func),
        .c_in      (c_in),
        .csh       (csh),
        .result    (result),
        .flags_out (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sh;
        logic [15:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got_r, input logic [3:0] got_f,
                         input logic [15:0] exp_r, input logic [3:0] exp_f);
        checks++;
        if (got_r !== exp_r || got_f !== exp_f) begin
            errors++;
            $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                     name, got_r, got_f, exp_r, exp_f);
        end
    endtask

    // Reference: integer arithmetic; overflow means the true signed sum is out of 16-bit range.
    task automatic model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sh,
                         output logic [15:0] r, output logic [3:0] fl);
        int ua, ub, sa, sb, cin_v, utot, stot;
        bit is_arith, v, c;
        is_arith = 1'b1;
        cin_v    = 0;
        ub       = int'(b);
        sb       = int'($signed(b));
        case (f)
            3'd0: cin_v = 0;
            3'd1: cin_v = int'(ci);
            3'd2: begin ub = 65535 - int'(b); sb = -sb - 1; cin_v = 1; end
            3'd3: begin ub = 65535 - int'(b); sb = -sb - 1; cin_v = int'(ci); end
            3'd4, 3'd5: is_arith = 1'b0;
            default: begin
`ifdef STUMP_ALU_LDST_EN
                cin_v = 0;
`else
                r  = 16'h0000;
                fl = 4'b0000;
                return;
`endif
            end
        endcase
        ua = int'(a);
        sa = int'($signed(a));
        if (is_arith) begin
            utot = ua + ub + cin_v;
            stot = sa + sb + cin_v;
            r    = utot[15:0];
            c    = (utot > 65535);
            v    = (stot > 32767) || (stot < -32768);
        end else begin
            r = (f == 3'd4) ? (a & b) : (a | b);
            c = sh;
            v = 1'b0;
        end
        fl = {r[15], (r == 16'h0000), v, c};
    endtask

    task automatic drive(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sh);
        func = f; operand_A = a; operand_B = b; c_in = ci; csh = sh;
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] er;
        logic [3:0]  ef;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rf;
        logic        rci;
        logic        rsh;

        vecs.push_back('{"add_c_in_ignored", 3'd0, 16'h4000, 16'h3FFF, 1'b1, 1'b0, 16'h7FFF, 4'b0000});
        vecs.push_back('{"adc_overflow",     3'd1, 16'h4000, 16'h3FFF, 1'b1, 1'b0, 16'h8000, 4'b1010});
        vecs.push_back('{"add_pos_ovf",      3'd0, 16'h5000, 16'h5000, 1'b0, 1'b0, 16'hA000, 4'b1010});
        vecs.push_back('{"add_neg_ovf",      3'd0, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 4'b0111});
        vecs.push_back('{"sub_basic",        3'd2, 16'h4000, 16'h3FFF, 1'b0, 1'b0, 16'h0001, 4'b0001});
        vecs.push_back('{"sub_equal",        3'd2, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b0101});
        vecs.push_back('{"sbc_borrow_in",    3'd3, 16'h4000, 16'h3FFF, 1'b0, 1'b0, 16'h0000, 4'b0101});
        vecs.push_back('{"sub_borrow",       3'd2, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 4'b1000});
        vecs.push_back('{"and_csh1",         3'd4, 16'hC000, 16'h4000, 1'b0, 1'b1, 16'h4000, 4'b0001});
        vecs.push_back('{"or_csh0",          3'd5, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h8000, 4'b1000});
        vecs.push_back('{"and_zero",         3'd4, 16'h4000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 4'b0100});
`ifdef STUMP_ALU_LDST_EN
        vecs.push_back('{"ld_addr",          3'd6, 16'h1234, 16'h0010, 1'b1, 1'b1, 16'h1244, 4'b0000});
        vecs.push_back('{"st_wrap",          3'd7, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 4'b0101});
`else
        vecs.push_back('{"ld_disabled",      3'd6, 16'h1234, 16'h0010, 1'b1, 1'b1, 16'h0000, 4'b0000});
        vecs.push_back('{"st_disabled",      3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000});
`endif

        drive(3'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("reset_state", result, flags_out, 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sh);
            @(posedge clk);
            #1;
            check(vecs[i].name, result, flags_out, vecs[i].exp_r, vecs[i].exp_f);
        end

        // Outputs must hold between edges when inputs change.
        drive(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(3'd5, 16'hF0F0, 16'h0F0F, 1'b1, 1'b1);
        #2;
        check("hold_between_edges", result, flags_out, 16'h3333, 4'b0000);

        // Async reset mid-cycle, then recovery on the first edge after release.
        drive(3'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_capture", result, flags_out, 16'h0000, 4'b0111);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", result, flags_out, 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", result, flags_out, 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", result, flags_out, 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        check("post_reset_capture", result, flags_out, 16'h0000, 4'b0111);

        for (int n = 0; n < 400; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rf  = 3'($urandom_range(0, 7));
            rci = 1'($urandom);
            rsh = 1'($urandom);
            if (n % 8 == 0) rb = ra;
            if (n % 8 == 1) ra = 16'h7FFF;
            model(rf, ra, rb, rci, rsh, er, ef);
            drive(rf, ra, rb, rci, rsh);
            @(posedge clk);
            #1;
            check($sformatf("random_%0d_f%0d", n, rf), result, flags_out, er, ef);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
